// File: rtl/mixer_nb_dec_pkg.sv
// Shared constants and elaboration-time helpers for the N-channel mixer/decimator.
package mixer_nb_dec_pkg;

   localparam int SHIFT_W = 6;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mixer_nb_dec_lane.sv
// One LO channel: I/Q products, integrate-and-dump accumulators, round and saturate.
module mixer_nb_dec_lane
   import mixer_nb_dec_pkg::*;
#(
   parameter int RF_BITS   = 1,
   parameter int LO_BITS   = 8,
   parameter int OUT_BITS  = 16,
   parameter int DECIM_MAX = 64
)
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                step1,
   input  logic                step2,
   input  logic                dump,
   input  logic [RF_BITS-1:0]  rf,
   input  logic [LO_BITS-1:0]  sin_lo,
   input  logic [LO_BITS-1:0]  cos_lo,
   input  logic [SHIFT_W-1:0]  shift,
   output logic [OUT_BITS-1:0] i_out,
   output logic [OUT_BITS-1:0] q_out,
   output logic                clip
);

   localparam int PROD_W = RF_BITS + LO_BITS;
   localparam int ACC_W  = PROD_W + clog2(DECIM_MAX);
   localparam int RW     = max2(ACC_W, OUT_BITS) + 1;
   localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (OUT_BITS - 1)) - RW'(1);
   localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

   logic signed [PROD_W-1:0]   mul_i, mul_q, prod_i, prod_q;
   logic signed [ACC_W-1:0]    acc_i, acc_q, sum_i, sum_q;
   logic        [OUT_BITS-1:0] res_i, res_q;
   logic                       clip_i, clip_q;

   // Sign mode maps bit 1 to +1 and bit 0 to -1; PROD_W leaves room for -(-2^(LO_BITS-1)).
   if (RF_BITS == 1) begin : g_sign
      always_comb begin
         mul_i = rf[0] ? PROD_W'($signed(cos_lo)) : -PROD_W'($signed(cos_lo));
         mul_q = rf[0] ? PROD_W'($signed(sin_lo)) : -PROD_W'($signed(sin_lo));
      end
   end else begin : g_mult
      always_comb begin
         mul_i = PROD_W'($signed(rf)) * PROD_W'($signed(cos_lo));
         mul_q = PROD_W'($signed(rf)) * PROD_W'($signed(sin_lo));
      end
   end

   // Round half up as floor(s / 2^k) plus bit k-1 of s; avoids overflow from adding the half LSB.
   function automatic logic [OUT_BITS-1:0] rnd_sat(input  logic signed [ACC_W-1:0] s,
                                                   input  logic [SHIFT_W-1:0]      k,
                                                   output logic                    c);
      logic signed [ACC_W-1:0] q;
      logic                    rb;
      logic signed [RW-1:0]    r;
      q  = s >>> k;
      rb = (k != '0) && (|(s & (ACC_W'(1) << (k - SHIFT_W'(1)))));
      r  = RW'(q) + RW'(rb);
      c  = 1'b0;
      if (r > MAXV) begin
         c = 1'b1;
         return MAXV[OUT_BITS-1:0];
      end else if (r < MINV) begin
         c = 1'b1;
         return MINV[OUT_BITS-1:0];
      end
      return r[OUT_BITS-1:0];
   endfunction

   always_comb begin
      sum_i = acc_i + ACC_W'(prod_i);
      sum_q = acc_q + ACC_W'(prod_q);
      res_i = rnd_sat(sum_i, shift, clip_i);
      res_q = rnd_sat(sum_q, shift, clip_q);
      clip  = clip_i | clip_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         prod_i <= '0;
         prod_q <= '0;
         acc_i  <= '0;
         acc_q  <= '0;
         i_out  <= '0;
         q_out  <= '0;
      end else begin
         if (step1) begin
            prod_i <= mul_i;
            prod_q <= mul_q;
         end
         if (step2) begin
            if (dump) begin
               acc_i <= '0;
               acc_q <= '0;
               i_out <= res_i;
               q_out <= res_q;
            end else begin
               acc_i <= sum_i;
               acc_q <= sum_q;
            end
         end
      end
   end

endmodule

// File: rtl/mixer_nb_dec.sv
// N-channel quadrature mixer with integrate-and-dump decimation; owns input stage,
// window counter and output strobes, one lane per LO channel.
module mixer_nb_dec
   import mixer_nb_dec_pkg::*;
#(
   parameter int RF_BITS   = 1,
   parameter int LO_BITS   = 8,
   parameter int OUT_BITS  = 16,
   parameter int NCH       = 2,
   parameter int DECIM_MAX = 64
)
(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic [RF_BITS-1:0]        RF_in,
   output logic [RF_BITS-1:0]        RF_out,
   input  logic [NCH*LO_BITS-1:0]    sin_in,
   input  logic [NCH*LO_BITS-1:0]    cos_in,
   input  logic [clog2(DECIM_MAX):0] DECIM,
   input  logic [SHIFT_W-1:0]        SHIFT,
   output logic [NCH*OUT_BITS-1:0]   I_out,
   output logic [NCH*OUT_BITS-1:0]   Q_out,
   output logic                      out_valid,
   output logic                      sat_out
);

   localparam int CW = clog2(DECIM_MAX) + 1;

   logic [RF_BITS-1:0]     rf_d1, rf_d2, rf_s0;
   logic [NCH*LO_BITS-1:0] sin_s0, cos_s0;
   logic                   v0, v1;
   logic [CW-1:0]          cnt, dec_act, dec_clamp;
   logic                   adv, dump;
   logic [NCH-1:0]         clip;

   always_comb begin
      dec_clamp = DECIM;
      if (DECIM == '0)
         dec_clamp = CW'(1);
      else if (DECIM > CW'(DECIM_MAX))
         dec_clamp = CW'(DECIM_MAX);
   end

   // v0/v1 mark stage 0/1 as holding a real sample, so windows never start on reset zeros.
   assign adv  = EN & v1;
   assign dump = adv & (cnt == dec_act - CW'(1));

   // out_valid is a one-cycle strobe with no ready: downstream must take I_out/Q_out/sat_out
   // on the cycle it is high; the values then hold until the next strobe.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rf_d1     <= '0;
         rf_d2     <= '0;
         RF_out    <= '0;
         rf_s0     <= '0;
         sin_s0    <= '0;
         cos_s0    <= '0;
         v0        <= 1'b0;
         v1        <= 1'b0;
         cnt       <= '0;
         dec_act   <= dec_clamp;
         out_valid <= 1'b0;
         sat_out   <= 1'b0;
      end else begin
         rf_d1     <= RF_in;
         rf_d2     <= rf_d1;
         RF_out    <= rf_d2;
         out_valid <= 1'b0;
         sat_out   <= 1'b0;
         if (EN) begin
            rf_s0  <= RF_in;
            sin_s0 <= sin_in;
            cos_s0 <= cos_in;
            v0     <= 1'b1;
            v1     <= v0;
            if (v1) begin
               if (dump) begin
                  cnt       <= '0;
                  dec_act   <= dec_clamp;
                  out_valid <= 1'b1;
                  sat_out   <= |clip;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         end
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      mixer_nb_dec_lane #(
         .RF_BITS   (RF_BITS),
         .LO_BITS   (LO_BITS),
         .OUT_BITS  (OUT_BITS),
         .DECIM_MAX (DECIM_MAX)
      ) u_lane (
         .CLK    (CLK),
         .RST    (RST),
         .step1  (EN),
         .step2  (adv),
         .dump   (dump),
         .rf     (rf_s0),
         .sin_lo (sin_s0[k*LO_BITS +: LO_BITS]),
         .cos_lo (cos_s0[k*LO_BITS +: LO_BITS]),
         .shift  (SHIFT),
         .i_out  (I_out[k*OUT_BITS +: OUT_BITS]),
         .q_out  (Q_out[k*OUT_BITS +: OUT_BITS]),
         .clip   (clip[k])
      );
   end

endmodule

// File: tb/tb_mixer_nb_dec.sv
// Bench for mixer_nb_dec: a sign-mode/8-bit-output instance and a 4-bit-RF/16-bit-output
// instance run in lockstep against a sample-queue reference model.
module tb_mixer_nb_dec;

   localparam int NCH   = 2;
   localparam int OA    = 8;
   localparam int OB    = 16;
   localparam int ACC_A = 1 + 8 + 6;
   localparam int ACC_B = 4 + 8 + 6;

   logic        CLK = 1'b0;
   logic        RST, EN;
   logic [0:0]  rf_a, rfo_a;
   logic [3:0]  rf_b, rfo_b;
   logic [15:0] sin_in, cos_in;
   logic [6:0]  DECIM;
   logic [5:0]  SHIFT;
   logic [15:0] ia, qa;
   logic [31:0] ib, qb;
   logic        va, sa, vb, sb;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mixer_nb_dec #(.RF_BITS(1), .LO_BITS(8), .OUT_BITS(OA), .NCH(NCH), .DECIM_MAX(64)) u_dut_a (
      .CLK(CLK), .RST(RST), .EN(EN), .RF_in(rf_a), .RF_out(rfo_a),
      .sin_in(sin_in), .cos_in(cos_in), .DECIM(DECIM), .SHIFT(SHIFT),
      .I_out(ia), .Q_out(qa), .out_valid(va), .sat_out(sa));

   mixer_nb_dec #(.RF_BITS(4), .LO_BITS(8), .OUT_BITS(OB), .NCH(NCH), .DECIM_MAX(64)) u_dut_b (
      .CLK(CLK), .RST(RST), .EN(EN), .RF_in(rf_b), .RF_out(rfo_b),
      .sin_in(sin_in), .cos_in(cos_in), .DECIM(DECIM), .SHIFT(SHIFT),
      .I_out(ib), .Q_out(qb), .out_valid(vb), .sat_out(sb));

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        rfa;
      logic [3:0]  rfb;
      logic [15:0] s;
      logic [15:0] c;
   } smp_t;

   smp_t       pq[$];
   logic [3:0] hist_a[$], hist_b[$];
   longint     acc  [2][NCH][2];
   longint     ex_o [2][NCH][2];
   int         cnt_m, dec_m;
   bit         ex_v;
   bit         ex_s [2];

   function automatic int clampd(input int d);
      if (d == 0) return 1;
      if (d > 64) return 64;
      return d;
   endfunction

   function automatic longint rf_val(input int d, input smp_t x);
      if (d == 0) return x.rfa ? 64'sd1 : -64'sd1;
      return longint'($signed(x.rfb));
   endfunction

   function automatic longint lo_val(input logic [15:0] v, input int ch);
      logic [7:0] b;
      b = v[ch*8 +: 8];
      return longint'($signed(b));
   endfunction

   function automatic longint rnd(input longint s, input int k, input int accw);
      longint half;
      half = 0;
      if (k > 0 && (k - 1) < accw) half = 64'sd1 <<< (k - 1);
      return (s + half) >>> k;
   endfunction

   function automatic longint sat(input longint r, input int ob, output bit c);
      longint hi, lo;
      hi = (64'sd1 <<< (ob - 1)) - 1;
      lo = -(64'sd1 <<< (ob - 1));
      c  = 1'b0;
      if (r > hi) begin c = 1'b1; return hi; end
      if (r < lo) begin c = 1'b1; return lo; end
      return r;
   endfunction

   task automatic model_reset();
      pq.delete();
      hist_a.delete();
      hist_b.delete();
      repeat (3) begin
         hist_a.push_back(4'd0);
         hist_b.push_back(4'd0);
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++)
            for (int j = 0; j < 2; j++) begin
               acc[d][c][j]  = 0;
               ex_o[d][c][j] = 0;
            end
      cnt_m   = 0;
      dec_m   = clampd(int'(DECIM));
      ex_v    = 1'b0;
      ex_s[0] = 1'b0;
      ex_s[1] = 1'b0;
   endtask

   task automatic model_edge();
      smp_t   x;
      longint p;
      bit     c;
      void'(hist_a.pop_front());
      void'(hist_b.pop_front());
      hist_a.push_back({3'd0, rf_a});
      hist_b.push_back(rf_b);
      if (RST) begin
         model_reset();
         return;
      end
      ex_v    = 1'b0;
      ex_s[0] = 1'b0;
      ex_s[1] = 1'b0;
      if (!EN) return;
      x.rfa = rf_a[0];
      x.rfb = rf_b;
      x.s   = sin_in;
      x.c   = cos_in;
      pq.push_back(x);
      if (pq.size() < 3) return;
      x = pq.pop_front();
      for (int d = 0; d < 2; d++)
         for (int ch = 0; ch < NCH; ch++) begin
            acc[d][ch][0] += rf_val(d, x) * lo_val(x.c, ch);
            acc[d][ch][1] += rf_val(d, x) * lo_val(x.s, ch);
         end
      cnt_m++;
      if (cnt_m == dec_m) begin
         for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < NCH; ch++)
               for (int j = 0; j < 2; j++) begin
                  p = rnd(acc[d][ch][j], int'(SHIFT), (d == 0) ? ACC_A : ACC_B);
                  ex_o[d][ch][j] = sat(p, (d == 0) ? OA : OB, c);
                  if (c) ex_s[d] = 1'b1;
                  acc[d][ch][j] = 0;
               end
         cnt_m = 0;
         dec_m = clampd(int'(DECIM));
         ex_v  = 1'b1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [15:0] e_ia, e_qa;
      logic [31:0] e_ib, e_qb;
      for (int ch = 0; ch < NCH; ch++) begin
         e_ia[ch*OA +: OA] = OA'(ex_o[0][ch][0]);
         e_qa[ch*OA +: OA] = OA'(ex_o[0][ch][1]);
         e_ib[ch*OB +: OB] = OB'(ex_o[1][ch][0]);
         e_qb[ch*OB +: OB] = OB'(ex_o[1][ch][1]);
      end
      check("valid_a", 64'(va), 64'(ex_v));
      check("valid_b", 64'(vb), 64'(ex_v));
      check("sat_a", 64'(sa), 64'(ex_s[0]));
      check("sat_b", 64'(sb), 64'(ex_s[1]));
      check("i_a", 64'(ia), 64'(e_ia));
      check("q_a", 64'(qa), 64'(e_qa));
      check("i_b", 64'(ib), 64'(e_ib));
      check("q_b", 64'(qb), 64'(e_qb));
      check("rfout_a", 64'(rfo_a), 64'(hist_a[0]));
      check("rfout_b", 64'(rfo_b), 64'(hist_b[0]));
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic reset_dut(input int n);
      RST = 1'b1;
      repeat (n) step();
      RST = 1'b0;
   endtask

   task automatic rand_in();
      sin_in = 16'($urandom());
      cos_in = 16'($urandom());
      rf_a   = 1'($urandom());
      rf_b   = 4'($urandom());
   endtask

   initial begin
      RST = 1'b1; EN = 1'b0; rf_a = '0; rf_b = '0;
      sin_in = '0; cos_in = '0; DECIM = 7'd1; SHIFT = 6'd0;
      model_reset();

      // Sign mode, DECIM=1, SHIFT=0: +/-cos on I, +/-sin on Q three edges later
      reset_dut(2);
      EN = 1'b1; cos_in = {8'd20, 8'd100}; sin_in = {8'd7, 8'hCE}; rf_a = 1'b1; rf_b = 4'd5;
      repeat (3) step();
      check("dir_valid", 64'(va), 64'd1);
      check("dir_i_pos", 64'(ia[7:0]), 64'h64);
      check("dir_q_pos", 64'(qa[7:0]), 64'hCE);
      rf_a = 1'b0;
      repeat (3) step();
      check("dir_i_neg", 64'(ia[7:0]), 64'h9C);
      check("dir_q_neg", 64'(qa[7:0]), 64'h32);

      // DECIM=4, SHIFT=2, constant cos=127, then alternating RF
      DECIM = 7'd4; SHIFT = 6'd2;
      reset_dut(1);
      cos_in = {8'd127, 8'd127}; sin_in = {8'd3, 8'hF0}; rf_a = 1'b1; rf_b = 4'd2;
      repeat (14) step();
      repeat (16) begin
         rf_a = ~rf_a;
         step();
      end

      // Saturation over a 64-sample window, positive then negative full scale
      DECIM = 7'd64; SHIFT = 6'd0;
      reset_dut(1);
      cos_in = {8'd127, 8'd127}; sin_in = {8'h80, 8'd1}; rf_a = 1'b1; rf_b = 4'd7;
      repeat (140) step();
      cos_in = {8'h80, 8'h80};
      repeat (140) step();

      // Rounding on the 4-bit RF instance: 9/2 -> 5, -9/2 -> -4
      DECIM = 7'd1; SHIFT = 6'd1;
      reset_dut(1);
      cos_in = {8'd3, 8'd3}; sin_in = {8'd1, 8'hFF}; rf_b = 4'd3; rf_a = 1'b1;
      repeat (3) step();
      check("dir_rnd_pos", 64'(ib[15:0]), 64'h0005);
      rf_b = 4'hD;
      repeat (3) step();
      check("dir_rnd_neg", 64'(ib[15:0]), 64'hFFFC);

      // DECIM change mid-window, then EN low for 10 cycles mid-window
      DECIM = 7'd4; SHIFT = 6'd0;
      reset_dut(1);
      repeat (7) begin rand_in(); step(); end
      DECIM = 7'd2;
      repeat (12) begin rand_in(); step(); end
      step();
      EN = 1'b0;
      repeat (10) begin rand_in(); step(); end
      EN = 1'b1;
      repeat (10) begin rand_in(); step(); end

      // Reset mid-window with DECIM=0 (treated as 1)
      DECIM = 7'd8;
      repeat (5) begin rand_in(); step(); end
      DECIM = 7'd0;
      reset_dut(1);
      repeat (8) begin rand_in(); step(); end

      // Randomized run: EN dropouts, DECIM/SHIFT changes incl. clamped and oversized values, resets
      for (int i = 0; i < 600; i++) begin
         rand_in();
         EN = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) DECIM = 7'($urandom_range(0, 70));
         if ($urandom_range(0, 19) == 0)
            SHIFT = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(14, 63)) : 6'($urandom_range(0, 10));
         RST = ($urandom_range(0, 149) == 0);
         step();
      end
      RST = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
